discharge_supervisor: RTL and testbench

Parametrised run/parameter supervisor placed between the host/key command sources and the MOSFET pulse generator. Merges NUM_SRC independent start/stop sources into one run enable, stages Ton/Toff/Ip/waveform writes in shadow registers, and commits them atomically only at a discharge-cycle boundary. Queues single-discharge button presses and issues them one at a time with a req/ack handshake. Latches an over-current fault that forces the machine off until cleared.

---
 rtl/discharge_supervisor_if.sv | 43 ++++
 rtl/discharge_supervisor.sv | 150 +++++++++++++++
 tb/tb_discharge_supervisor.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/discharge_supervisor_if.sv
// Command/parameter/shot/status bundle between host-side sources and discharge_supervisor.
// Latency: none, wires only.
// Backpressure: shot_req is held until shot_ack; all other strobes are single-cycle with no backpressure.
interface discharge_supervisor_if #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 16
);
  logic [NUM_SRC-1:0] start_ack;
  logic [NUM_SRC-1:0] stop_ack;
  logic               param_wr;
  logic [1:0]         param_sel;
  logic [DATA_W-1:0]  param_wdata;
  logic               cycle_boundary;
  logic signed [15:0] sample_current;
  logic               shot_btn;
  logic               shot_ack;
  logic               status_clr;
  logic               is_machine;
  logic [DATA_W-1:0]  Ton;
  logic [DATA_W-1:0]  Toff;
  logic [DATA_W-1:0]  Ip;
  logic [DATA_W-1:0]  waveform;
  logic               param_pending;
  logic               shot_req;
  logic               shot_overflow;
  logic               fault;

  // Host / command-source side
  modport master (
    output start_ack, stop_ack, param_wr, param_sel, param_wdata, cycle_boundary,
           sample_current, shot_btn, shot_ack, status_clr,
    input  is_machine, Ton, Toff, Ip, waveform, param_pending, shot_req,
           shot_overflow, fault
  );

  // Supervisor side
  modport slave (
    input  start_ack, stop_ack, param_wr, param_sel, param_wdata, cycle_boundary,
           sample_current, shot_btn, shot_ack, status_clr,
    output is_machine, Ton, Toff, Ip, waveform, param_pending, shot_req,
           shot_overflow, fault
  );
endinterface

// File: rtl/discharge_supervisor.sv
// Run/parameter supervisor: merges start/stop sources, stages parameters, queues single shots, latches over-current (DSUP_OC_TRIP_EN).
// Latency: run enable, commit, fault and queue count all update on the edge that samples their inputs.
// Backpressure: shot_req held until shot_ack; presses beyond SHOT_DEPTH are dropped and flagged in shot_overflow.
module discharge_supervisor #(
  parameter int                 NUM_SRC      = 2,
  parameter logic [NUM_SRC-1:0] RST_RUN_MASK = 2'b01,
  parameter int                 DATA_W       = 16,
  parameter int                 SHOT_DEPTH   = 4,
  parameter logic [15:0]        OC_LIMIT     = 16'd78,
  parameter int                 OC_FILTER    = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  discharge_supervisor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  localparam int              CW      = $clog2(SHOT_DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(SHOT_DEPTH);

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] run, run_nxt;
  logic               trip;

  logic [DATA_W-1:0]  shadow [4];
  logic [DATA_W-1:0]  active [4];
  logic               pending;
  logic               commit;

  logic [CW-1:0]      cnt;
  logic               overflow;
  logic               shot_req;
  logic               dec;

  // Stop beats start when both arrive on the same source in one cycle
  assign run_nxt = (run | bus.start_ack) & ~bus.stop_ack;

  // Per-source run latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= RST_RUN_MASK;
    else        run <= run_nxt;
  end

`ifdef DSUP_OC_TRIP_EN
  localparam logic [7:0] OC_LAST = 8'(OC_FILTER - 1);

  logic [16:0] cur_ext;
  logic [16:0] cur_mag;
  logic        over;
  logic [7:0]  oc_cnt;

  // 17-bit magnitude so that -32768 maps to +32768 instead of wrapping
  always_comb begin
    cur_ext = {bus.sample_current[15], bus.sample_current};
    cur_mag = bus.sample_current[15] ? (17'd0 - cur_ext) : cur_ext;
    over    = cur_mag > {1'b0, OC_LIMIT};
    trip    = over && (oc_cnt == OC_LAST) && (state != FAULT);
  end

  // Consecutive over-limit counter; any in-limit sample restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                oc_cnt <= '0;
    else if (!over)            oc_cnt <= '0;
    else if (oc_cnt != OC_LAST) oc_cnt <= oc_cnt + 8'd1;
  end
`else
  logic unused_sample;

  // Without the over-current option the sample input is ignored and FAULT is never entered
  assign unused_sample = ^bus.sample_current;
  assign trip          = 1'b0;
`endif

  // Next-state: run enable follows the updated latches, trip overrides, FAULT waits for a clear
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trip) state_nxt = FAULT;
               else if (&run_nxt) state_nxt = RUN;
      RUN:     if (trip) state_nxt = FAULT;
               else if (!(&run_nxt)) state_nxt = IDLE;
      FAULT:   if (bus.status_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outside RUN there is no discharge in flight, so pending data may commit immediately
  assign commit = pending && (bus.cycle_boundary || (state != RUN));

  // Shadow writes and atomic commit; a same-cycle write lands in shadow after the copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      pending <= 1'b0;
    end else begin
      if (commit) begin
        for (int i = 0; i < 4; i++) active[i] <= shadow[i];
      end
      if (bus.param_wr) begin
        shadow[bus.param_sel] <= bus.param_wdata;
        pending               <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  assign shot_req = (cnt != '0) && (state == IDLE);
  assign dec      = shot_req && bus.shot_ack;

  // Shot queue counter; fault entry discards queued presses, overflow set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (trip) begin
        cnt <= '0;
      end else if (bus.shot_btn && !dec) begin
        if (cnt != DEPTH_C) cnt <= cnt + 1'b1;
      end else if (dec && !bus.shot_btn) begin
        cnt <= cnt - 1'b1;
      end

      if (bus.shot_btn && !dec && (cnt == DEPTH_C) && !trip) overflow <= 1'b1;
      else if (bus.status_clr)                             overflow <= 1'b0;
    end
  end

  assign bus.is_machine    = (state == RUN);
  assign bus.Ton           = active[0];
  assign bus.Toff          = active[1];
  assign bus.Ip            = active[2];
  assign bus.waveform      = active[3];
  assign bus.param_pending = pending;
  assign bus.shot_req      = shot_req;
  assign bus.shot_overflow = overflow;
  assign bus.fault         = (state == FAULT);

endmodule

// File: tb/tb_discharge_supervisor.sv
// Directed bench for discharge_supervisor with default parameters.
// Expectations for the over-current steps depend on whether DSUP_OC_TRIP_EN is defined.
module tb_discharge_supervisor;

`ifdef DSUP_OC_TRIP_EN
  localparam bit TRIP = 1'b1;
`else
  localparam bit TRIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  discharge_supervisor_if #(.NUM_SRC(2), .DATA_W(16)) bus ();

  discharge_supervisor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n               = 1'b0;
    bus.start_ack       = '0;
    bus.stop_ack        = '0;
    bus.param_wr        = 1'b0;
    bus.param_sel       = 2'd0;
    bus.param_wdata     = '0;
    bus.cycle_boundary  = 1'b0;
    bus.sample_current  = 16'sd0;
    bus.shot_btn        = 1'b0;
    bus.shot_ack        = 1'b0;
    bus.status_clr      = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_is_machine", 32'(bus.is_machine), 32'd0);
    chk("rst_ton", 32'(bus.Ton), 32'd0);
    chk("rst_pending", 32'(bus.param_pending), 32'd0);
    chk("rst_shot_req", 32'(bus.shot_req), 32'd0);
    chk("rst_overflow", 32'(bus.shot_overflow), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst", 32'(bus.is_machine), 32'd0);

    // Source 1 completes the mask
    bus.start_ack = 2'b10; tick(); bus.start_ack = '0;
    chk("start_run", 32'(bus.is_machine), 32'd1);

    // Staged writes in RUN wait for the cycle boundary
    bus.param_wr = 1'b1; bus.param_sel = 2'd0; bus.param_wdata = 16'd50; tick();
    bus.param_sel = 2'd2; bus.param_wdata = 16'd30; tick();
    bus.param_wr = 1'b0;
    chk("staged_ton", 32'(bus.Ton), 32'd0);
    chk("staged_ip", 32'(bus.Ip), 32'd0);
    chk("staged_pending", 32'(bus.param_pending), 32'd1);
    tick();
    chk("no_boundary_ton", 32'(bus.Ton), 32'd0);
    bus.cycle_boundary = 1'b1; tick(); bus.cycle_boundary = 1'b0;
    chk("commit_ton", 32'(bus.Ton), 32'd50);
    chk("commit_ip", 32'(bus.Ip), 32'd30);
    chk("commit_toff", 32'(bus.Toff), 32'd0);
    chk("commit_pending", 32'(bus.param_pending), 32'd0);

    // Write coinciding with commit stays in shadow
    bus.param_wr = 1'b1; bus.param_sel = 2'd0; bus.param_wdata = 16'd60; tick();
    bus.param_sel = 2'd1; bus.param_wdata = 16'd200; bus.cycle_boundary = 1'b1; tick();
    bus.param_wr = 1'b0; bus.cycle_boundary = 1'b0;
    chk("coinc_ton", 32'(bus.Ton), 32'd60);
    chk("coinc_toff", 32'(bus.Toff), 32'd0);
    chk("coinc_ip", 32'(bus.Ip), 32'd30);
    chk("coinc_pending", 32'(bus.param_pending), 32'd1);
    bus.cycle_boundary = 1'b1; tick(); bus.cycle_boundary = 1'b0;
    chk("second_toff", 32'(bus.Toff), 32'd200);
    chk("second_pending", 32'(bus.param_pending), 32'd0);

    // Start and stop on source 0 together: stop wins
    bus.start_ack = 2'b01; bus.stop_ack = 2'b01; tick();
    bus.start_ack = '0; bus.stop_ack = '0;
    chk("stop_wins", 32'(bus.is_machine), 32'd0);

    // Five presses into a depth-4 queue
    bus.shot_btn = 1'b1; tick();
    chk("shot_req_rise", 32'(bus.shot_req), 32'd1);
    repeat (4) tick();
    bus.shot_btn = 1'b0;
    chk("overflow_set", 32'(bus.shot_overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("handshake_%0d", i), 32'(bus.shot_req), 32'd1);
      bus.shot_ack = 1'b1; tick(); bus.shot_ack = 1'b0;
    end
    chk("queue_drained", 32'(bus.shot_req), 32'd0);

    // Ack with no request must not underflow
    bus.shot_ack = 1'b1; tick(); bus.shot_ack = 1'b0;
    bus.shot_btn = 1'b1; tick(); bus.shot_btn = 1'b0;
    chk("no_underflow", 32'(bus.shot_req), 32'd1);
    bus.shot_ack = 1'b1; tick(); bus.shot_ack = 1'b0;
    chk("single_done", 32'(bus.shot_req), 32'd0);
    chk("overflow_sticky", 32'(bus.shot_overflow), 32'd1);
    bus.status_clr = 1'b1; tick(); bus.status_clr = 1'b0;
    chk("overflow_clr", 32'(bus.shot_overflow), 32'd0);

    // Overflow set beats a same-cycle clear
    bus.shot_btn = 1'b1; repeat (4) tick();
    bus.status_clr = 1'b1; tick();
    bus.shot_btn = 1'b0; bus.status_clr = 1'b0;
    chk("set_beats_clr", 32'(bus.shot_overflow), 32'd1);
    bus.status_clr = 1'b1; tick(); bus.status_clr = 1'b0;
    chk("overflow_clr2", 32'(bus.shot_overflow), 32'd0);
    bus.shot_ack = 1'b1; repeat (4) tick(); bus.shot_ack = 1'b0;
    chk("drained2", 32'(bus.shot_req), 32'd0);

    // Back to RUN, filter restart then trip
    bus.start_ack = 2'b01; tick(); bus.start_ack = '0;
    chk("rerun", 32'(bus.is_machine), 32'd1);
    bus.sample_current = 16'sd79; repeat (3) tick();
    bus.sample_current = 16'sd10; tick();
    chk("filter_restart_fault", 32'(bus.fault), 32'd0);
    bus.sample_current = 16'sd79; repeat (3) tick();
    chk("three_over_fault", 32'(bus.fault), 32'd0);
    tick();
    bus.sample_current = 16'sd0;
    chk("trip_fault", 32'(bus.fault), 32'(TRIP));
    chk("trip_is_machine", 32'(bus.is_machine), 32'(!TRIP));
    bus.status_clr = 1'b1; tick(); bus.status_clr = 1'b0;
    chk("clr_fault", 32'(bus.fault), 32'd0);
    chk("clr_idle", 32'(bus.is_machine), 32'(!TRIP));
    tick();
    chk("clr_then_run", 32'(bus.is_machine), 32'd1);

    // Negative over-current with queued shots flushes the queue
    bus.shot_btn = 1'b1; repeat (2) tick(); bus.shot_btn = 1'b0;
    chk("run_no_shot_req", 32'(bus.shot_req), 32'd0);
    bus.sample_current = -16'sd80; repeat (4) tick();
    bus.sample_current = 16'sd0;
    chk("neg_trip_fault", 32'(bus.fault), 32'(TRIP));
    chk("neg_trip_shot_req", 32'(bus.shot_req), 32'd0);
    bus.stop_ack = 2'b01; tick(); bus.stop_ack = '0;
    bus.status_clr = 1'b1; tick(); bus.status_clr = 1'b0;
    chk("flush_shot_req", 32'(bus.shot_req), 32'(!TRIP));
    chk("flush_fault", 32'(bus.fault), 32'd0);
    chk("flush_is_machine", 32'(bus.is_machine), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
